// File: rtl/flu_rewrite_4b_pkg.sv
// Shared constants, log2 helper and per-frame rewrite context for flu_rewrite_4b.
// The context mask field is only driven from a port when FLU_REWRITE_4B_MASK_EN is defined.
package flu_rewrite_4b_pkg;

    function automatic int flu_log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    localparam int FLU_DATA_WIDTH    = 512;
    localparam int FLU_SOP_POS_WIDTH = 3;
    localparam int FLU_OFFSET_WIDTH  = 10;

    localparam int BYTES         = FLU_DATA_WIDTH / 8;
    localparam int BLK_BYTES     = BYTES >> FLU_SOP_POS_WIDTH;
    localparam int EOP_POS_WIDTH = flu_log2(BYTES);
    localparam int CTX_OFF_W     = FLU_OFFSET_WIDTH;

    typedef struct packed {
        logic [CTX_OFF_W-1:0] offset;
        logic [31:0]          data;
        logic                 enable;
        logic [3:0]           mask;
    } ctx_t;

endpackage

// File: rtl/flu_rewrite_4b_mask.sv
// Combinational per-byte write decision: which bytes of the current word fall inside
// a frame's 4-byte write span, and which context/lane supplies each replaced byte.
module flu_rewrite_4b_mask
    import flu_rewrite_4b_pkg::*;
#(
    parameter int NBYTES       = BYTES,
    parameter int OFFSET_WIDTH = FLU_OFFSET_WIDTH,
    parameter int EOPW         = EOP_POS_WIDTH
) (
    input  logic                      sop,
    input  logic                      eop,
    input  logic                      active,
    input  logic [EOPW-1:0]           sop_byte,
    input  logic [EOPW-1:0]           eop_pos,
    input  logic [OFFSET_WIDTH:0]     fcnt,
    input  logic [OFFSET_WIDTH-1:0]   cap_off,
    input  logic                      cap_en,
    input  logic [3:0]                cap_mask,
    input  logic [OFFSET_WIDTH-1:0]   new_off,
    input  logic                      new_en,
    input  logic [3:0]                new_mask,
    output logic [NBYTES-1:0]         we,
    output logic [NBYTES-1:0][2:0]    sel
);
    // Wide enough that fcnt + byte index and offset + 3 never wrap.
    localparam int IW = OFFSET_WIDTH + 2 + EOPW;

    logic new_ends;
    assign new_ends = eop && (eop_pos >= sop_byte);

    for (genvar i = 0; i < NBYTES; i++) begin : g_byte
        localparam logic [EOPW-1:0] BI = EOPW'(i);
        logic          own_new;
        logic          en;
        logic          ends_ok;
        logic          in_span;
        logic [3:0]    msk;
        logic [IW-1:0] idx;
        logic [IW-1:0] off;
        logic [IW-1:0] rel;

        assign own_new = sop && (BI >= sop_byte);
        assign idx     = own_new ? IW'(BI - sop_byte) : IW'(fcnt) + IW'(i);
        assign off     = own_new ? IW'(new_off) : IW'(cap_off);
        assign en      = own_new ? new_en : (cap_en && active);
        assign msk     = own_new ? new_mask : cap_mask;
        assign rel     = idx - off;
        assign in_span = (idx >= off) && (rel <= IW'(3));
        // Bytes past the owning frame's EOP are never written.
        assign ends_ok = (own_new ? !new_ends : !eop) || (BI <= eop_pos);
        assign we[i]   = en && in_span && ends_ok && msk[rel[1:0]];
        assign sel[i]  = {own_new, rel[1:0]};
    end

endmodule

// File: rtl/flu_rewrite_4b.sv
// Overwrites frame bytes OFFSET..OFFSET+3 of an FLU stream with NEW_DATA, one register stage.
// Define FLU_REWRITE_4B_MASK_EN to add the NEW_MASK per-byte write mask port.
module flu_rewrite_4b
    import flu_rewrite_4b_pkg::*;
#(
    parameter int DATA_WIDTH    = FLU_DATA_WIDTH,
    parameter int SOP_POS_WIDTH = FLU_SOP_POS_WIDTH,
    parameter int OFFSET_WIDTH  = FLU_OFFSET_WIDTH,
    localparam int NBYTES       = DATA_WIDTH / 8,
    localparam int EOPW         = flu_log2(DATA_WIDTH / 8)
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [DATA_WIDTH-1:0]    RX_DATA,
    input  logic [SOP_POS_WIDTH-1:0] RX_SOP_POS,
    input  logic [EOPW-1:0]          RX_EOP_POS,
    input  logic                     RX_SOP,
    input  logic                     RX_EOP,
    input  logic                     RX_SRC_RDY,
    output logic                     RX_DST_RDY,
    input  logic [OFFSET_WIDTH-1:0]  OFFSET,
    input  logic [31:0]              NEW_DATA,
    input  logic                     ENABLE,
`ifdef FLU_REWRITE_4B_MASK_EN
    input  logic [3:0]               NEW_MASK,
`endif
    output logic [DATA_WIDTH-1:0]    TX_DATA,
    output logic [SOP_POS_WIDTH-1:0] TX_SOP_POS,
    output logic [EOPW-1:0]          TX_EOP_POS,
    output logic                     TX_SOP,
    output logic                     TX_EOP,
    output logic                     TX_SRC_RDY,
    input  logic                     TX_DST_RDY
);
    localparam int LOG_BLK = EOPW - SOP_POS_WIDTH;
    localparam int FW      = OFFSET_WIDTH + 1;
    localparam logic [FW-1:0] FCNT_MAX = '1;

    logic                     tx_vld_q, tx_vld_d;
    logic                     tx_sop_q, tx_sop_d;
    logic                     tx_eop_q, tx_eop_d;
    logic [SOP_POS_WIDTH-1:0] tx_sop_pos_q, tx_sop_pos_d;
    logic [EOPW-1:0]          tx_eop_pos_q, tx_eop_pos_d;
    logic [DATA_WIDTH-1:0]    tx_data_q, tx_data_d;
    logic                     active_q, active_d;
    logic [FW-1:0]            fcnt_q, fcnt_d;
    ctx_t                     ctx_q, ctx_d;
    ctx_t                     new_ctx;

    logic                     rx_rdy;
    logic                     rx_fire;
    logic [EOPW-1:0]          sop_byte;
    logic [FW:0]              fcnt_sum;
    logic [NBYTES-1:0]        we;
    logic [NBYTES-1:0][2:0]   sel;
    logic [DATA_WIDTH-1:0]    data_mod;

    assign rx_rdy   = TX_DST_RDY || !tx_vld_q;
    assign rx_fire  = RX_SRC_RDY && rx_rdy;
    assign sop_byte = EOPW'(RX_SOP_POS) << LOG_BLK;

    always_comb begin
        new_ctx.offset = CTX_OFF_W'(OFFSET);
        new_ctx.data   = NEW_DATA;
        new_ctx.enable = ENABLE;
`ifdef FLU_REWRITE_4B_MASK_EN
        new_ctx.mask   = NEW_MASK;
`else
        new_ctx.mask   = 4'hF;
`endif
    end

    flu_rewrite_4b_mask #(
        .NBYTES       (NBYTES),
        .OFFSET_WIDTH (OFFSET_WIDTH),
        .EOPW         (EOPW)
    ) u_mask (
        .sop      (RX_SOP),
        .eop      (RX_EOP),
        .active   (active_q),
        .sop_byte (sop_byte),
        .eop_pos  (RX_EOP_POS),
        .fcnt     (fcnt_q),
        .cap_off  (OFFSET_WIDTH'(ctx_q.offset)),
        .cap_en   (ctx_q.enable),
        .cap_mask (ctx_q.mask),
        .new_off  (OFFSET),
        .new_en   (ENABLE),
        .new_mask (new_ctx.mask),
        .we       (we),
        .sel      (sel)
    );

    // Frame tracking: a new frame starts with the bytes after its SOP block already counted.
    always_comb begin
        active_d = active_q;
        fcnt_d   = fcnt_q;
        ctx_d    = ctx_q;
        fcnt_sum = {1'b0, fcnt_q} + (FW+1)'(NBYTES);
        if (rx_fire) begin
            if (RX_SOP) begin
                active_d = !(RX_EOP && (RX_EOP_POS >= sop_byte));
                fcnt_sum = (FW+1)'(NBYTES) - (FW+1)'(sop_byte);
                ctx_d    = new_ctx;
            end else if (active_q) begin
                active_d = !RX_EOP;
            end
            if (RX_SOP || active_q) begin
                fcnt_d = fcnt_sum[FW] ? FCNT_MAX : fcnt_sum[FW-1:0];
            end
        end
    end

    always_comb begin
        data_mod = RX_DATA;
        for (int i = 0; i < NBYTES; i++) begin
            if (we[i]) begin
                data_mod[8*i +: 8] = sel[i][2] ? new_ctx.data[8*sel[i][1:0] +: 8]
                                               : ctx_q.data[8*sel[i][1:0] +: 8];
            end
        end
    end

    always_comb begin
        tx_vld_d     = tx_vld_q;
        tx_sop_d     = tx_sop_q;
        tx_eop_d     = tx_eop_q;
        tx_sop_pos_d = tx_sop_pos_q;
        tx_eop_pos_d = tx_eop_pos_q;
        tx_data_d    = tx_data_q;
        if (rx_rdy) begin
            tx_vld_d = RX_SRC_RDY;
            if (RX_SRC_RDY) begin
                tx_sop_d     = RX_SOP;
                tx_eop_d     = RX_EOP;
                tx_sop_pos_d = RX_SOP_POS;
                tx_eop_pos_d = RX_EOP_POS;
                tx_data_d    = data_mod;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            tx_vld_q     <= 1'b0;
            tx_sop_q     <= 1'b0;
            tx_eop_q     <= 1'b0;
            tx_sop_pos_q <= '0;
            tx_eop_pos_q <= '0;
            tx_data_q    <= '0;
            active_q     <= 1'b0;
            fcnt_q       <= '0;
            ctx_q        <= '0;
        end else begin
            tx_vld_q     <= tx_vld_d;
            tx_sop_q     <= tx_sop_d;
            tx_eop_q     <= tx_eop_d;
            tx_sop_pos_q <= tx_sop_pos_d;
            tx_eop_pos_q <= tx_eop_pos_d;
            tx_data_q    <= tx_data_d;
            active_q     <= active_d;
            fcnt_q       <= fcnt_d;
            ctx_q        <= ctx_d;
        end
    end

    assign RX_DST_RDY = rx_rdy;
    assign TX_SRC_RDY = tx_vld_q;
    assign TX_SOP     = tx_sop_q;
    assign TX_EOP     = tx_eop_q;
    assign TX_SOP_POS = tx_sop_pos_q;
    assign TX_EOP_POS = tx_eop_pos_q;
    assign TX_DATA    = tx_data_q;

endmodule

// File: tb/tb_flu_rewrite_4b.sv
// Frame-level bench for flu_rewrite_4b: frames are rewritten byte-wise by index, then packed
// into FLU words; random valid/ready gaps with stall-stability and reset checks.
`timescale 1ns/1ps
module tb_flu_rewrite_4b;
    localparam int DW   = 512;
    localparam int NB   = 64;
    localparam int NBLK = 8;
    localparam int BLK  = 8;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [DW-1:0] RX_DATA;
    logic [2:0]    RX_SOP_POS;
    logic [5:0]    RX_EOP_POS;
    logic          RX_SOP, RX_EOP, RX_SRC_RDY, RX_DST_RDY;
    logic [9:0]    OFFSET;
    logic [31:0]   NEW_DATA;
    logic          ENABLE;
`ifdef FLU_REWRITE_4B_MASK_EN
    logic [3:0]    NEW_MASK;
`endif
    logic [DW-1:0] TX_DATA;
    logic [2:0]    TX_SOP_POS;
    logic [5:0]    TX_EOP_POS;
    logic          TX_SOP, TX_EOP, TX_SRC_RDY, TX_DST_RDY;

    always #5 CLK = ~CLK;

    flu_rewrite_4b dut (
        .CLK(CLK), .RESET(RESET),
        .RX_DATA(RX_DATA), .RX_SOP_POS(RX_SOP_POS), .RX_EOP_POS(RX_EOP_POS),
        .RX_SOP(RX_SOP), .RX_EOP(RX_EOP), .RX_SRC_RDY(RX_SRC_RDY), .RX_DST_RDY(RX_DST_RDY),
        .OFFSET(OFFSET), .NEW_DATA(NEW_DATA), .ENABLE(ENABLE),
`ifdef FLU_REWRITE_4B_MASK_EN
        .NEW_MASK(NEW_MASK),
`endif
        .TX_DATA(TX_DATA), .TX_SOP_POS(TX_SOP_POS), .TX_EOP_POS(TX_EOP_POS),
        .TX_SOP(TX_SOP), .TX_EOP(TX_EOP), .TX_SRC_RDY(TX_SRC_RDY), .TX_DST_RDY(TX_DST_RDY)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [DW-1:0] exp;
        logic          sop;
        logic          eop;
        logic [2:0]    sop_pos;
        logic [5:0]    eop_pos;
        logic [9:0]    off;
        logic [31:0]   nd;
        logic          en;
        logic [3:0]    mk;
    } word_t;

    word_t wq[$];
    word_t cw;
    bit    cw_open = 0;
    int    pos = 0;
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic word_t rand_word();
        word_t w;
        for (int i = 0; i < DW/32; i++) w.data[32*i +: 32] = $urandom;
        w.exp     = w.data;
        w.sop     = 1'b0;
        w.eop     = 1'b0;
        w.sop_pos = 3'($urandom);
        w.eop_pos = 6'($urandom);
        w.off     = 10'($urandom);
        w.nd      = $urandom;
        w.en      = 1'($urandom);
        w.mk      = 4'($urandom);
        return w;
    endfunction

    // Model: frame byte k takes NEW_DATA byte (k-off) when enabled, in span and masked in.
    task automatic add_frame(input int len, input int off, input logic [31:0] nd,
                             input bit en, input logic [3:0] mk, input int blk);
        int b, start, p, rel;
        bit shared;
        logic [7:0] ob, eb;
        shared = 0;
        start  = 0;
        if (cw_open && !cw.sop) begin
            b = (pos + BLK - 1) / BLK;
            if (b < NBLK && len > NB - b*BLK) begin
                if (blk >= b) begin
                    shared = 1; start = blk;
                end else if (blk < 0 && $urandom_range(0, 1) == 1) begin
                    shared = 1; start = $urandom_range(b, NBLK-1);
                end
            end
        end
        if (!shared) begin
            if (cw_open) wq.push_back(cw);
            cw = rand_word();
            start = (blk >= 0) ? blk : $urandom_range(0, NBLK-1);
        end
        cw.sop = 1'b1; cw.sop_pos = 3'(start);
        cw.off = 10'(off); cw.nd = nd; cw.en = en; cw.mk = mk;
        p = start * BLK;
        for (int k = 0; k < len; k++) begin
            if (p == NB) begin
                wq.push_back(cw);
                cw = rand_word();
                p = 0;
            end
            ob = 8'($urandom);
            eb = ob;
            rel = k - off;
            if (en && rel >= 0 && rel <= 3 && mk[rel]) eb = nd[8*rel +: 8];
            cw.data[8*p +: 8] = ob;
            cw.exp[8*p +: 8]  = eb;
            p++;
        end
        cw.eop = 1'b1; cw.eop_pos = 6'(p - 1);
        pos = p; cw_open = 1;
        if (pos == NB) begin
            wq.push_back(cw);
            cw_open = 0;
        end
    endtask

    task automatic set_rx(input word_t w, input logic vld);
        RX_DATA = w.data; RX_SOP = w.sop; RX_EOP = w.eop;
        RX_SOP_POS = w.sop_pos; RX_EOP_POS = w.eop_pos;
        OFFSET = w.off; NEW_DATA = w.nd; ENABLE = w.en;
`ifdef FLU_REWRITE_4B_MASK_EN
        NEW_MASK = w.mk;
`endif
        RX_SRC_RDY = vld;
    endtask

    task automatic drive(input int idx);
        word_t w;
        if (idx < wq.size() && $urandom_range(0, 4) != 0) begin
            set_rx(wq[idx], 1'b1);
        end else begin
            w = rand_word();
            w.sop = 1'($urandom); w.eop = 1'($urandom);
            set_rx(w, 1'b0);
        end
        TX_DST_RDY = 1'($urandom);
    endtask

    initial begin
        word_t w0, w1, orph;
        logic [3:0] mk;
        int len, off, idx, oidx, cyc;
        bit acc, stalled;
        logic [DW-1:0] h_data;
        logic [11:0]   h_ctl;

        w0 = rand_word(); w0.sop = 1'b0; w0.eop = 1'b0;
        set_rx(w0, 1'b0);
        TX_DST_RDY = 1'b0;
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_src_rdy", TX_SRC_RDY, 0);
        chk("rst_sop", TX_SOP, 0);
        chk("rst_eop", TX_EOP, 0);
        chk("rst_data", TX_DATA, '0);
        chk("rst_sop_pos", TX_SOP_POS, 0);
        chk("rst_eop_pos", TX_EOP_POS, 0);
        chk("rst_dst_rdy", RX_DST_RDY, 1);

        // First two words of a 3-word frame, then reset before the third.
        @(posedge CLK); #1;
        RESET = 1'b0;
        w0 = rand_word(); w0.sop = 1'b1; w0.eop = 1'b0; w0.sop_pos = 3'd0;
        w0.en = 1'b1; w0.off = 10'd130; w0.mk = 4'hF;
        set_rx(w0, 1'b1);
        TX_DST_RDY = 1'b1;
        @(posedge CLK); #1;
        chk("lat_vld", TX_SRC_RDY, 1);
        chk("lat_sop", TX_SOP, 1);
        chk("lat_data", TX_DATA, w0.data);
        w1 = rand_word(); w1.sop = 1'b0; w1.eop = 1'b0;
        set_rx(w1, 1'b1);
        @(posedge CLK); #1;
        RX_SRC_RDY = 1'b0;
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        chk("rst_mid_vld", TX_SRC_RDY, 0);

        // Leftover third word of the discarded frame must pass untouched.
        orph = rand_word(); orph.eop = 1'b1;
        wq.push_back(orph);
        add_frame(40, 5, $urandom, 1, 4'hF, 0);
        add_frame(64, 10, 32'hDDCCBBAA, 1, 4'hF, 0);
        add_frame(128, 62, 32'hDDCCBBAA, 1, 4'hF, 0);
        add_frame(12, 10, 32'hDDCCBBAA, 1, 4'hF, 0);
        add_frame(85, 63, $urandom, 1, 4'hF, 0);
        add_frame(100, 0, $urandom, 1, 4'hF, 4);
`ifdef FLU_REWRITE_4B_MASK_EN
        add_frame(30, 3, 32'h44332211, 1, 4'b0101, 0);
`endif
        add_frame(2200, 1020, $urandom, 1, 4'hF, -1);
        add_frame(1030, 1023, $urandom, 1, 4'hF, -1);
        for (int f = 0; f < 1000; f++) begin
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 12) : $urandom_range(1, 200);
            off = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, len + 3);
`ifdef FLU_REWRITE_4B_MASK_EN
            mk = 4'($urandom);
`else
            mk = 4'hF;
`endif
            add_frame(len, off, $urandom, (f % 2) == 0, mk, -1);
        end
        if (cw_open) wq.push_back(cw);

        idx = 0; oidx = 0; cyc = 0; stalled = 0;
        h_data = '0; h_ctl = '0;
        drive(0);
        while (oidx < wq.size() && cyc < 60000) begin
            @(negedge CLK);
            acc = RX_SRC_RDY && RX_DST_RDY;
            if (stalled) begin
                chk("stall_data", TX_DATA, h_data);
                chk("stall_ctl", {TX_SRC_RDY, TX_SOP, TX_EOP, TX_SOP_POS, TX_EOP_POS}, h_ctl);
            end
            stalled = TX_SRC_RDY && !TX_DST_RDY;
            h_data  = TX_DATA;
            h_ctl   = {TX_SRC_RDY, TX_SOP, TX_EOP, TX_SOP_POS, TX_EOP_POS};
            if (TX_SRC_RDY && TX_DST_RDY) begin
                chk("data", TX_DATA, wq[oidx].exp);
                chk("ctl", {TX_SOP, TX_EOP, TX_SOP_POS, TX_EOP_POS},
                    {wq[oidx].sop, wq[oidx].eop, wq[oidx].sop_pos, wq[oidx].eop_pos});
                oidx++;
            end
            @(posedge CLK); #1;
            if (acc) idx++;
            drive(idx);
            cyc++;
        end
        chk("drain_count", oidx, wq.size());

        RX_SRC_RDY = 1'b0;
        TX_DST_RDY = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("no_extra_word", TX_SRC_RDY, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
